// File: rtl/bist_pattern_checker.sv
// Exhaustive-pattern BIST harness: drives every input pattern into a
// combinational block, compacts its responses in a MISR, checks a golden value.
module bist_pattern_checker #(
    parameter int               N_IN       = 3,
    parameter int               N_OUT      = 3,
    parameter int               SIG_W      = 16,
    parameter logic [SIG_W-1:0] SIG_POLY   = SIG_W'(16'h1021),
    parameter logic [SIG_W-1:0] SIG_SEED   = SIG_W'(16'h0000),
    parameter logic [SIG_W-1:0] GOLDEN_SIG = SIG_W'(16'h0000),
    parameter int               SETTLE     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  pat_out,
    input  logic [N_OUT-1:0] resp_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // One extra counter bit so the last pattern is found by compare, not wrap.
    localparam logic [N_IN:0] LAST     = {1'b0, {N_IN{1'b1}}};
    localparam logic [3:0]    SETTLE_C = 4'(SETTLE);

    state_t           state;
    state_t           state_d;
    logic [N_IN:0]    cnt;
    logic [N_IN:0]    cnt_d;
    logic [3:0]       settle_cnt;
    logic [3:0]       settle_d;
    logic [SIG_W-1:0] sig;
    logic [SIG_W-1:0] sig_d;
    logic [SIG_W-1:0] sig_upd;
    logic [SIG_W-1:0] resp_ext;
    logic             busy_d;
    logic             done_d;
    logic             pass_d;

    // MISR step: shift, fold the feedback tap, xor in the zero-extended response.
    always_comb begin
        resp_ext = '0;
        resp_ext[N_OUT-1:0] = resp_in;
        sig_upd = {sig[SIG_W-2:0], 1'b0}
                ^ (sig[SIG_W-1] ? SIG_POLY : '0)
                ^ resp_ext;
    end

    // Next-state and next-output decode; everything holds unless told otherwise.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        settle_d = settle_cnt;
        sig_d    = sig;
        busy_d   = busy;
        done_d   = done;
        pass_d   = pass;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    cnt_d    = '0;
                    sig_d    = SIG_SEED;
                    settle_d = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end else if (settle_cnt < SETTLE_C) begin
                    settle_d = settle_cnt + 4'd1;
                end else begin
                    sig_d    = sig_upd;
                    settle_d = '0;
                    if (cnt == LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (sig_upd == GOLDEN_SIG);
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            settle_cnt <= '0;
            sig        <= SIG_SEED;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            settle_cnt <= settle_d;
            sig        <= sig_d;
            busy       <= busy_d;
            done       <= done_d;
            pass       <= pass_d;
        end
    end

    assign pat_out   = cnt[N_IN-1:0];
    assign signature = sig;

endmodule

// File: tb/tb_bist_pattern_checker.sv
// Scoreboard bench: five harness configurations run side by side on shared
// controls; a negedge monitor checks each finished run against queued results.
module tb_bist_pattern_checker;

    localparam int NI = 5;
    localparam int SETTLE_A [NI] = '{1, 1, 1, 0, 2};
    localparam logic [15:0] SEED_A [NI] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h5};
    localparam logic [15:0] ESIG_A [NI] = '{16'h0, 16'h0F, 16'h0F, 16'h0F, 16'hD};
    localparam logic EPASS_A [NI] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam int ECYC_A [NI] = '{16, 16, 16, 8, 24};

    typedef struct {
        logic [15:0] sig;
        logic        pass;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start, abort;

    logic [2:0]  p0, p1, p2, p3, p4;
    logic [15:0] s0;
    logic [7:0]  s1, s2, s3;
    logic [3:0]  s4;
    logic [NI-1:0] busy_a, done_a, pass_a;
    logic [15:0] sig_a [NI];
    logic [2:0]  pat_a [NI];

    int checks = 0;
    int errors = 0;

    exp_t q0[$], q1[$], q2[$], q3[$], q4[$];

    always #5 clk = ~clk;

    bist_pattern_checker u0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pat_out(p0), .resp_in(3'b000), .busy(busy_a[0]),
        .done(done_a[0]), .pass(pass_a[0]), .signature(s0));

    bist_pattern_checker #(.SIG_W(8), .SIG_POLY(8'h07), .SIG_SEED(8'h00),
        .GOLDEN_SIG(8'h0F), .SETTLE(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pat_out(p1), .resp_in(p1), .busy(busy_a[1]),
        .done(done_a[1]), .pass(pass_a[1]), .signature(s1));

    bist_pattern_checker #(.SIG_W(8), .SIG_POLY(8'h07), .SIG_SEED(8'h00),
        .GOLDEN_SIG(8'h0E), .SETTLE(1)) u2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pat_out(p2), .resp_in(p2), .busy(busy_a[2]),
        .done(done_a[2]), .pass(pass_a[2]), .signature(s2));

    bist_pattern_checker #(.SIG_W(8), .SIG_POLY(8'h07), .SIG_SEED(8'h00),
        .GOLDEN_SIG(8'h0F), .SETTLE(0)) u3 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pat_out(p3), .resp_in(p3), .busy(busy_a[3]),
        .done(done_a[3]), .pass(pass_a[3]), .signature(s3));

    bist_pattern_checker #(.SIG_W(4), .SIG_POLY(4'h3), .SIG_SEED(4'h5),
        .GOLDEN_SIG(4'hD), .SETTLE(2)) u4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pat_out(p4), .resp_in(p4), .busy(busy_a[4]),
        .done(done_a[4]), .pass(pass_a[4]), .signature(s4));

    assign sig_a[0] = s0;
    assign sig_a[1] = {8'h00, s1};
    assign sig_a[2] = {8'h00, s2};
    assign sig_a[3] = {8'h00, s3};
    assign sig_a[4] = {12'h000, s4};
    assign pat_a[0] = p0;
    assign pat_a[1] = p1;
    assign pat_a[2] = p2;
    assign pat_a[3] = p3;
    assign pat_a[4] = p4;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic push_all();
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            e.sig  = ESIG_A[i];
            e.pass = EPASS_A[i];
            e.cyc  = ECYC_A[i];
            case (i)
                0: q0.push_back(e);
                1: q1.push_back(e);
                2: q2.push_back(e);
                3: q3.push_back(e);
                default: q4.push_back(e);
            endcase
        end
    endtask

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            3: return q3.size();
            default: return q4.size();
        endcase
    endfunction

    function automatic exp_t pop_exp(input int i);
        case (i)
            0: return q0.pop_front();
            1: return q1.pop_front();
            2: return q2.pop_front();
            3: return q3.pop_front();
            default: return q4.pop_front();
        endcase
    endfunction

    // Monitor: pattern sequencing while busy, full result on each done rise.
    initial begin
        int bcnt [NI];
        logic [NI-1:0] busy_q;
        logic [NI-1:0] done_q;
        exp_t e;
        busy_q = '0;
        done_q = '0;
        for (int i = 0; i < NI; i++) bcnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (busy_a[i]) begin
                    bcnt[i] = busy_q[i] ? bcnt[i] + 1 : 1;
                    chk($sformatf("pat%0d_c%0d", i, bcnt[i]),
                        {13'h0, pat_a[i]},
                        16'((bcnt[i] - 1) / (SETTLE_A[i] + 1)));
                end
                if (done_a[i] && !done_q[i]) begin
                    if (qsize(i) == 0) begin
                        chk($sformatf("unexp_done%0d", i), 16'd1, 16'd0);
                    end else begin
                        e = pop_exp(i);
                        chk($sformatf("sig%0d", i), sig_a[i], e.sig);
                        chk($sformatf("pass%0d", i), {15'h0, pass_a[i]},
                            {15'h0, e.pass});
                        chk($sformatf("lat%0d", i), 16'(bcnt[i]),
                            16'(e.cyc));
                    end
                end
            end
            busy_q = busy_a;
            done_q = done_a;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_all_done();
        for (int k = 0; k < 300; k++) begin
            if (&done_a) break;
            tick();
        end
        if (!(&done_a)) chk("done_timeout", {11'h0, done_a}, 16'h1F);
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s_busy%0d", tag, i), {15'h0, busy_a[i]}, 16'h0);
            chk($sformatf("%s_done%0d", tag, i), {15'h0, done_a[i]}, 16'h0);
            chk($sformatf("%s_pass%0d", tag, i), {15'h0, pass_a[i]}, 16'h0);
            chk($sformatf("%s_pat%0d", tag, i), {13'h0, pat_a[i]}, 16'h0);
            chk($sformatf("%s_sig%0d", tag, i), sig_a[i], SEED_A[i]);
        end
    endtask

    localparam logic [2:0]  APAT_A [NI] = '{3'd2, 3'd2, 3'd2, 3'd4, 3'd1};
    localparam logic [15:0] ASIG_A [NI] = '{16'h0, 16'h1, 16'h1, 16'h3, 16'hA};

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) tick();
        check_reset("rst");
        rst = 1'b0;
        tick();

        push_all();
        pulse_start();
        repeat (3) tick();
        pulse_start();
        wait_all_done();

        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("hold_done%0d", i), {15'h0, done_a[i]}, 16'h1);
            chk($sformatf("hold_busy%0d", i), {15'h0, busy_a[i]}, 16'h0);
            chk($sformatf("hold_sig%0d", i), sig_a[i], ESIG_A[i]);
            chk($sformatf("hold_pass%0d", i), {15'h0, pass_a[i]},
                {15'h0, EPASS_A[i]});
        end

        pulse_start();
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("abt_busy%0d", i), {15'h0, busy_a[i]}, 16'h0);
            chk($sformatf("abt_done%0d", i), {15'h0, done_a[i]}, 16'h0);
            chk($sformatf("abt_pass%0d", i), {15'h0, pass_a[i]}, 16'h0);
            chk($sformatf("abt_pat%0d", i), {13'h0, pat_a[i]},
                {13'h0, APAT_A[i]});
            chk($sformatf("abt_sig%0d", i), sig_a[i], ASIG_A[i]);
        end

        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("idle_abt_busy%0d", i), {15'h0, busy_a[i]}, 16'h0);
            chk($sformatf("idle_abt_sig%0d", i), sig_a[i], ASIG_A[i]);
        end

        push_all();
        pulse_start();
        wait_all_done();

        pulse_start();
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("mid_rst");

        push_all();
        pulse_start();
        repeat (2) tick();
        pulse_start();
        repeat (2) tick();
        pulse_start();
        wait_all_done();

        repeat (3) tick();
        for (int i = 0; i < NI; i++)
            chk($sformatf("q_left%0d", i), 16'(qsize(i)), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
